uop_serial_compare: RTL and testbench
=====================================

# uop_serial_compare

Bit-serial word comparator that consumes the per-bit equality stage (the team's `uop_nxor` cell) and accumulates its results over a WIDTH-bit word. Two serial streams arrive one bit per valid cycle. The block reports three results on a one-cycle `done` pulse:
- the captured equality vector,
- a mismatch count,
- a whole-word match flag.

It sits directly downstream of the XNOR stage, as the checking element of the lab's serial-link exercises.

## Interface
Parameters:
- `WIDTH`, 8: bits per compared word; legal range 2–64.
- `CNT_W`, `$clog2(WIDTH+1)`: derived width of the mismatch count; not overridden.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `n_reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin a new word comparison; sampled only in IDLE.
- `bit_valid`  in  1  `a_bit`/`b_bit` carry a valid bit this cycle.
- `a_bit`  in  1  serial stream A, LSB first.
- `b_bit`  in  1  serial stream B, LSB first.
- `busy`  out  1  high in RUN and DONE.
- `done`  out  1  one-cycle pulse; results are valid from this cycle on.
- `match`  out  1  1 when all WIDTH bits were equal.
- `mismatches`  out  CNT_W  number of unequal bit positions, 0..WIDTH.
- `eq_vec`  out  WIDTH  per-bit XNOR results; bit i is the i-th accepted bit pair.

## Operation
- Reset (asynchronous on `n_reset` low) forces:
  - state = IDLE
  - `busy`, `done`, `match` = 0
  - `mismatches` = 0
  - `eq_vec` = 0
  - internal bit index = 0
- States are IDLE, RUN and DONE.
  - IDLE, `start`=1: go to RUN. Clear `mismatches`, `eq_vec`, `match` and the bit index.
  - IDLE, `start`=0: stay in IDLE. `bit_valid` is ignored.
  - RUN, `bit_valid`=1: accept one bit.
    - eq = XNOR(`a_bit`, `b_bit`).
    - `eq_vec[index]` <= eq.
    - `mismatches` increments when eq=0.
    - index increments.
  - RUN, `bit_valid`=0: hold all state. No timeout.
  - RUN, accepting bit index WIDTH-1: go to DONE. On the same edge, set `match` <= (final mismatch count == 0).
  - DONE: `done`=1 for exactly one cycle, then return to IDLE unconditionally.
- `start` is ignored in RUN and DONE; it is not queued.
- `bit_valid` in DONE is ignored; that bit is lost.
- `match`, `mismatches` and `eq_vec` hold their values after DONE until the next accepted `start` clears them.
- The count saturates naturally at WIDTH and never wraps.
- Reset mid-word abandons the word. After reset is released, nothing resumes until a fresh `start`.

## Timing
- `done`, `match`, `mismatches`, `busy` and `eq_vec` are all registered. No combinational input-to-output path.
- `start` is sampled at edge E0, so `busy`=1 from E0.
- The first bit can be accepted at edge E0+1.
- Minimum latency: with `bit_valid` held high, bits are accepted at E1..E_WIDTH.
  - `done` is high in the cycle after E_WIDTH.
  - The block is back in IDLE, with `busy`=0, after E_WIDTH+1.
- Back-to-back words: `start` asserted in the cycle after `done` is accepted. The minimum period is WIDTH+2 cycles.
- Each `bit_valid` gap adds exactly one cycle per idle cycle.

## Structure
- Package `uop_cmp_pkg` holds:
  - the state typedef `cmp_state_t` {IDLE, RUN, DONE}
  - the default-width constant `CMP_WIDTH_DEFAULT` = 8
- Sub-module: one instance of the existing `uop_nxor` cell produces the per-bit equality from `a_bit`/`b_bit`. No new gate module is written.
- One FSM, one index counter, one mismatch counter and the `eq_vec` register, all in `uop_serial_compare`.

## Test plan
All scenarios use WIDTH=8.
1. Reset: `n_reset` low mid-RUN after 3 bits -> all outputs 0 immediately. After release, `bit_valid` pulses without `start` -> no change.
2. Equal words: A=B=0xA5 streamed LSB first with `bit_valid` held high -> `done` 9 cycles after the `start` edge, `match`=1, `mismatches`=0, `eq_vec`=0xFF.
3. Unequal words: A=0xF0, B=0x0F -> `match`=0, `mismatches`=8, `eq_vec`=0x00. Then A=0x81, B=0x80 -> `mismatches`=1, `eq_vec`=0xFE.
4. Gaps: A=B=0x3C with `bit_valid` dropped for 2 cycles after bit 2 and 1 cycle after bit 5 -> `done` 12 cycles after `start`, `match`=1.
5. Ignored controls: `start` pulsed during RUN and during DONE, and `bit_valid` high during DONE -> no restart, and the count is unaffected.
6. Hold and back-to-back: results stay stable for 5 idle cycles after `done`, then clear on the next `start`. A second word started the cycle after `done` completes correctly.

Source files
------------

// File: rtl/uop_cmp_pkg.sv
// Shared types and constants for the bit-serial word comparator.
package uop_cmp_pkg;

    localparam int CMP_WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } cmp_state_t;

endpackage

// File: rtl/uop_nxor.sv
// Per-bit equality cell: y is 1 when a and b carry the same value.
module uop_nxor (
    input  logic a,
    input  logic b,
    output logic y
);

    assign y = ~(a ^ b);

endmodule

// File: rtl/uop_serial_compare.sv
// Bit-serial word comparator: accumulates per-bit XNOR results over WIDTH
// accepted bit pairs and reports equality vector, mismatch count and match flag.
module uop_serial_compare
    import uop_cmp_pkg::*;
#(
    parameter int WIDTH = CMP_WIDTH_DEFAULT,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             n_reset,
    input  logic             start,
    input  logic             bit_valid,
    input  logic             a_bit,
    input  logic             b_bit,
    output logic             busy,
    output logic             done,
    output logic             match,
    output logic [CNT_W-1:0] mismatches,
    output logic [WIDTH-1:0] eq_vec
);

    localparam int IDX_W = $clog2(WIDTH);

    cmp_state_t       state;
    cmp_state_t       next_state;
    logic [IDX_W-1:0] bit_idx;
    logic             bit_eq;
    logic             accept;
    logic             last_bit;

    uop_nxor u_nxor (
        .a (a_bit),
        .b (b_bit),
        .y (bit_eq)
    );

    assign accept   = (state == RUN) && bit_valid;
    assign last_bit = (bit_idx == IDX_W'(WIDTH - 1));

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = RUN;
            RUN:     if (accept && last_bit) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // busy/done are flopped from next_state so they are true register outputs.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= next_state;
            busy  <= (next_state != IDLE);
            done  <= (next_state == DONE);
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            bit_idx    <= '0;
            mismatches <= '0;
            eq_vec     <= '0;
            match      <= 1'b0;
        end else if (state == IDLE && start) begin
            bit_idx    <= '0;
            mismatches <= '0;
            eq_vec     <= '0;
            match      <= 1'b0;
        end else if (accept) begin
            eq_vec[bit_idx] <= bit_eq;
            if (!bit_eq) begin
                mismatches <= mismatches + CNT_W'(1);
            end
            if (last_bit) begin
                bit_idx <= '0;
                match   <= (mismatches == '0) && bit_eq;
            end else begin
                bit_idx <= bit_idx + IDX_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_uop_serial_compare.sv
// Self-checking bench for uop_serial_compare (WIDTH=8) against a word-level model.
module tb_uop_serial_compare;

    localparam int W  = 8;
    localparam int CW = 4;

    logic          clk       = 1'b0;
    logic          n_reset   = 1'b1;
    logic          start     = 1'b0;
    logic          bit_valid = 1'b0;
    logic          a_bit     = 1'b0;
    logic          b_bit     = 1'b0;
    logic          busy;
    logic          done;
    logic          match;
    logic [CW-1:0] mismatches;
    logic [W-1:0]  eq_vec;

    int n_compared   = 0;
    int n_mismatched = 0;
    bit check_en     = 1'b0;

    // Model state: the words accepted so far, how many bits, and control phase.
    logic         m_busy  = 1'b0;
    logic         m_done  = 1'b0;
    logic         m_match = 1'b0;
    logic [W-1:0] m_a     = '0;
    logic [W-1:0] m_b     = '0;
    int           m_taken = 0;

    uop_serial_compare #(.WIDTH(W)) dut (
        .clk        (clk),
        .n_reset    (n_reset),
        .start      (start),
        .bit_valid  (bit_valid),
        .a_bit      (a_bit),
        .b_bit      (b_bit),
        .busy       (busy),
        .done       (done),
        .match      (match),
        .mismatches (mismatches),
        .eq_vec     (eq_vec)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            m_busy = 1'b0; m_done = 1'b0; m_match = 1'b0;
            m_a = '0; m_b = '0; m_taken = 0;
        end else if (m_done) begin
            m_done = 1'b0;
            m_busy = 1'b0;
        end else if (!m_busy) begin
            if (start) begin
                m_busy = 1'b1; m_match = 1'b0;
                m_a = '0; m_b = '0; m_taken = 0;
            end
        end else if (bit_valid) begin
            m_a[m_taken] = a_bit;
            m_b[m_taken] = b_bit;
            m_taken++;
            if (m_taken == W) begin
                m_done  = 1'b1;
                m_match = (m_a == m_b);
            end
        end
    end

    function automatic logic [W-1:0] exp_eq_vec();
        logic [W-1:0] r = '0;
        for (int i = 0; i < m_taken; i++) r[i] = (m_a[i] == m_b[i]);
        return r;
    endfunction

    function automatic int exp_mismatches();
        int n = 0;
        for (int i = 0; i < m_taken; i++) if (m_a[i] != m_b[i]) n++;
        return n;
    endfunction

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            check_output("busy",       64'(busy),       64'(m_busy));
            check_output("done",       64'(done),       64'(m_done));
            check_output("match",      64'(match),      64'(m_match));
            check_output("mismatches", 64'(mismatches), 64'(exp_mismatches()));
            check_output("eq_vec",     64'(eq_vec),     64'(exp_eq_vec()));
        end
    end

    // Streams one word from idle; gaps[i] idle cycles follow bit i. Returns
    // the number of edges after the start edge at which done is first seen.
    task automatic apply_stimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input int gaps[W], input bit noise, output int done_edge);
        int edges = 0;
        int guard = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < W; i++) begin
            bit_valid = 1'b1; a_bit = a[i]; b_bit = b[i];
            if (noise) start = 1'($urandom_range(0, 1));
            @(posedge clk); #1; edges++;
            bit_valid = 1'b0; start = 1'b0;
            for (int g = 0; g < gaps[i]; g++) begin
                if (noise) begin
                    start = 1'($urandom_range(0, 1));
                    a_bit = 1'($urandom_range(0, 1));
                end
                @(posedge clk); #1; edges++;
                start = 1'b0;
            end
        end
        while (!done && guard < 20) begin
            @(posedge clk); #1; edges++; guard++;
        end
        if (!done) begin
            n_compared++; n_mismatched++;
            $display("[TB] FAIL done_timeout: got done=0 expected done=1 within bound");
        end
        done_edge = edges;
        if (noise) begin
            start = 1'b1; bit_valid = 1'b1; a_bit = 1'($urandom_range(0, 1));
        end
        @(posedge clk); #1;
        start = 1'b0; bit_valid = 1'b0;
    endtask

    initial begin
        #20000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int gaps[W];
        int de;
        int gap_sum;
        logic [W-1:0] ra, rb;

        #1 n_reset = 1'b0;
        check_en = 1'b1;
        repeat (2) @(posedge clk);
        #1 n_reset = 1'b1;
        check_output("rst_busy",   64'(busy),   64'd0);
        check_output("rst_eq_vec", 64'(eq_vec), 64'd0);

        // Reset mid-word, then bit_valid without start must do nothing.
        start = 1'b1; @(posedge clk); #1; start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bit_valid = 1'b1; a_bit = 1'b1; b_bit = 1'(i % 2);
            @(posedge clk); #1;
        end
        bit_valid = 1'b0;
        #2 n_reset = 1'b0;
        #1;
        check_output("midrst_busy",       64'(busy),       64'd0);
        check_output("midrst_mismatches", 64'(mismatches), 64'd0);
        check_output("midrst_eq_vec",     64'(eq_vec),     64'd0);
        @(posedge clk); #1 n_reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bit_valid = 1'b1; a_bit = 1'(i % 2); b_bit = 1'b0;
            @(posedge clk); #1;
        end
        bit_valid = 1'b0;
        check_output("nostart_busy",   64'(busy),   64'd0);
        check_output("nostart_eq_vec", 64'(eq_vec), 64'd0);

        gaps = '{default: 0};
        apply_stimulus(8'hA5, 8'hA5, gaps, 1'b0, de);
        check_output("eq_done_edge",  64'(de),         64'd8);
        check_output("eq_match",      64'(match),      64'd1);
        check_output("eq_mismatches", 64'(mismatches), 64'd0);
        check_output("eq_eq_vec",     64'(eq_vec),     64'hFF);

        apply_stimulus(8'hF0, 8'h0F, gaps, 1'b0, de);
        check_output("neq_match",      64'(match),      64'd0);
        check_output("neq_mismatches", 64'(mismatches), 64'd8);
        check_output("neq_eq_vec",     64'(eq_vec),     64'h00);

        apply_stimulus(8'h81, 8'h80, gaps, 1'b0, de);
        check_output("one_mismatches", 64'(mismatches), 64'd1);
        check_output("one_eq_vec",     64'(eq_vec),     64'hFE);

        gaps[2] = 2; gaps[5] = 1;
        apply_stimulus(8'h3C, 8'h3C, gaps, 1'b0, de);
        check_output("gap_done_edge", 64'(de),    64'd11);
        check_output("gap_match",     64'(match), 64'd1);

        gaps = '{default: 0};
        gaps[1] = 1; gaps[4] = 2;
        apply_stimulus(8'h5A, 8'h5B, gaps, 1'b1, de);
        check_output("noise_done_edge",  64'(de),         64'd11);
        check_output("noise_mismatches", 64'(mismatches), 64'd1);
        check_output("noise_eq_vec",     64'(eq_vec),     64'hFE);

        // Results hold through idle cycles, then back-to-back words follow.
        repeat (5) @(posedge clk);
        #1;
        check_output("hold_mismatches", 64'(mismatches), 64'd1);
        check_output("hold_eq_vec",     64'(eq_vec),     64'hFE);
        gaps = '{default: 0};
        apply_stimulus(8'h12, 8'h13, gaps, 1'b0, de);
        apply_stimulus(8'hC3, 8'hC3, gaps, 1'b0, de);
        check_output("b2b_match",  64'(match),  64'd1);
        check_output("b2b_eq_vec", 64'(eq_vec), 64'hFF);

        for (int w = 0; w < 30; w++) begin
            ra = W'($urandom);
            case ($urandom_range(0, 2))
                0:       rb = ra;
                1:       rb = ra ^ (W'(1) << $urandom_range(0, W - 1));
                default: rb = W'($urandom);
            endcase
            gap_sum = 0;
            for (int i = 0; i < W; i++) begin
                gaps[i] = (i < W - 1 && $urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
                gap_sum += gaps[i];
            end
            apply_stimulus(ra, rb, gaps, 1'($urandom_range(0, 1)), de);
            check_output("rand_done_edge", 64'(de), 64'(W + gap_sum));
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end

        check_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
